// File: rtl/load_store_unit_if.sv
// Request, response and Data_mem signals of the load/store unit.
// slave  : the load/store unit's view (takes requests, drives Data_mem).
// master : the surrounding environment's view (CPU execute stage plus Data_mem).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic [31:0] mem_readData;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_readData,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_write, mem_address, mem_writeData
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_readData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_write, mem_address, mem_writeData
  );
endinterface

// File: rtl/load_store_unit.sv
// Sub-word load/store engine between the execute stage and word-wide Data_mem.
// Byte/half/word requests become aligned word accesses; sub-word stores are
// read-modify-write; loads are sign- or zero-extended; misaligned requests
// finish with resp_err and no memory access.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    load_store_unit_if.slave: req_* handshake in, resp_* out,
//          mem_* to/from Data_mem
module load_store_unit #(
  parameter int unsigned MEM_READ_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  localparam int unsigned CNT_W = 2;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t           state_q, state_d;
  req_t             req_q, req_d, req_in;
  logic [31:0]      word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // Misalignment / reserved-size detection.
  function automatic logic is_mis(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: is_mis = 1'b0;
      SZ_HALF: is_mis = a[0];
      SZ_WORD: is_mis = (a != 2'b00);
      default: is_mis = 1'b1;
    endcase
  endfunction

  // Select the addressed lane(s) of the captured word and extend.
  function automatic logic [31:0] extend(input req_t r, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{r.addr[1:0], 3'b000} +: 8];
    h = r.addr[1] ? word[31:16] : word[15:0];
    case (r.size)
      SZ_BYTE: extend = {{24{~r.uns & b[7]}}, b};
      SZ_HALF: extend = {{16{~r.uns & h[15]}}, h};
      default: extend = word;
    endcase
  endfunction

  // Replace only the addressed lane(s) of the captured word with store data.
  function automatic logic [31:0] merge(input req_t r, input logic [31:0] word);
    merge = word;
    case (r.size)
      SZ_BYTE: merge[{r.addr[1:0], 3'b000} +: 8]  = r.wdata[7:0];
      SZ_HALF: merge[{r.addr[1], 4'b0000} +: 16] = r.wdata[15:0];
      default: merge = r.wdata;
    endcase
  endfunction

  assign req_in = '{write: bus.req_write, size: bus.req_size, uns: bus.req_unsigned,
                    addr: bus.req_addr, wdata: bus.req_wdata};

  // Next state, latched fields and next output values.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    word_d  = word_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          req_d = req_in;
          if (is_mis(req_in.size, req_in.addr[1:0])) begin
            state_d = RESP;
          end else if (!req_in.write || (req_in.size != SZ_WORD)) begin
            state_d = READ;
            cnt_d   = CNT_W'(MEM_READ_LATENCY - 1);
          end else begin
            state_d = WRITE;
          end
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          word_d  = bus.mem_readData;
          state_d = req_q.write ? WRITE : RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase

    ready_d       = (state_d == IDLE);
    mem_write_d   = (state_d == WRITE);
    mem_address_d = ((state_d == READ) || (state_d == WRITE)) ?
                    {req_d.addr[31:2], 2'b00} : 32'h0;
    mem_wdata_d   = (state_d == WRITE) ? merge(req_d, word_d) : 32'h0;
    resp_valid_d  = (state_d == RESP);
    resp_err_d    = (state_d == RESP) && is_mis(req_d.size, req_d.addr[1:0]);
    resp_rdata_d  = ((state_d == RESP) && !req_d.write && !is_mis(req_d.size, req_d.addr[1:0])) ?
                    extend(req_d, word_d) : 32'h0;
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      req_q         <= '0;
      word_q        <= 32'h0;
      cnt_q         <= '0;
      ready_q       <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      resp_err_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'h0;
      mem_wdata_q   <= 32'h0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      word_q        <= word_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writeData = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (read latency 1 and 3), each with
// its own Data_mem model, checked against a request-level reference model.
module tb_load_store_unit;
  localparam int unsigned L0 = 1;
  localparam int unsigned L1 = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  load_store_unit_if bus0();
  load_store_unit_if bus1();

  load_store_unit #(.MEM_READ_LATENCY(L0)) dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
  load_store_unit #(.MEM_READ_LATENCY(L1)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

  // Request drive, shared by both instances; valid is steered by sel.
  logic        sel;
  logic        d_valid, d_write, d_uns;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;

  assign bus0.req_valid = d_valid && !sel;
  assign bus1.req_valid = d_valid && sel;
  assign bus0.req_write = d_write;     assign bus1.req_write = d_write;
  assign bus0.req_size = d_size;       assign bus1.req_size = d_size;
  assign bus0.req_unsigned = d_uns;    assign bus1.req_unsigned = d_uns;
  assign bus0.req_addr = d_addr;       assign bus1.req_addr = d_addr;
  assign bus0.req_wdata = d_wdata;     assign bus1.req_wdata = d_wdata;

  // Data_mem models: 64 words indexed by address bits [7:2].
  logic [31:0] dmem0 [64];
  logic [31:0] dmem1 [64];
  logic [31:0] img   [64];
  logic        load_img;
  logic [31:0] a1, a2;

  always @(posedge clock) begin
    if (load_img) begin
      for (int i = 0; i < 64; i++) begin
        dmem0[i] <= img[i];
        dmem1[i] <= img[i];
      end
    end else begin
      if (bus0.mem_write) dmem0[bus0.mem_address[7:2]] <= bus0.mem_writeData;
      if (bus1.mem_write) dmem1[bus1.mem_address[7:2]] <= bus1.mem_writeData;
    end
  end

  // Latency 1: read data valid in the same cycle as the address.
  assign bus0.mem_readData = dmem0[bus0.mem_address[7:2]];
  // Latency 3: valid only once the address has been stable for three cycles.
  always @(posedge clock) begin
    a1 <= bus1.mem_address;
    a2 <= a1;
  end
  assign bus1.mem_readData = (a1 == bus1.mem_address && a2 == a1) ? dmem1[a2[7:2]] : 32'hA5A5_5A5A;

  // Observed outputs of the selected instance.
  logic        o_ready, o_resp_valid, o_resp_err, o_mem_write;
  logic [31:0] o_resp_rdata, o_mem_address, o_mem_wdata;
  assign o_ready       = sel ? bus1.req_ready     : bus0.req_ready;
  assign o_resp_valid  = sel ? bus1.resp_valid    : bus0.resp_valid;
  assign o_resp_err    = sel ? bus1.resp_err      : bus0.resp_err;
  assign o_resp_rdata  = sel ? bus1.resp_rdata    : bus0.resp_rdata;
  assign o_mem_write   = sel ? bus1.mem_write     : bus0.mem_write;
  assign o_mem_address = sel ? bus1.mem_address   : bus0.mem_address;
  assign o_mem_wdata   = sel ? bus1.mem_writeData : bus0.mem_writeData;

  // Reference memory contents, per instance.
  logic [31:0] mm [2][64];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request on instance s; returns observed resp_rdata.
  task automatic do_req(input logic s, input logic wr, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd, output logic [31:0] got);
    int          lat, idx, resp_k, wr_k, nwr;
    int unsigned sh;
    logic        mis;
    logic [31:0] word, lane, mask, exp_rdata, exp_wdata, wr_addr, wr_data, rs_addr;
    logic        exp_err, rs_err;
    int          exp_resp_k, exp_wr_k, exp_nwr;

    lat  = s ? int'(L1) : int'(L0);
    idx  = int'(ad[7:2]);
    word = mm[s][idx];
    mis  = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
    exp_rdata = 32'h0; exp_wdata = 32'h0; exp_err = 1'b0;
    exp_wr_k = 0; exp_nwr = 0;
    if (sz == 2'b00) begin
      sh = 8 * int'(ad[1:0]); mask = 32'hFF;
    end else begin
      sh = 16 * int'(ad[1]);  mask = 32'hFFFF;
    end
    if (mis) begin
      exp_err = 1'b1; exp_resp_k = 1;
    end else if (!wr) begin
      exp_resp_k = lat + 1;
      if (sz == 2'b10) exp_rdata = word;
      else begin
        lane = (word >> sh) & mask;
        if (!un && lane > (mask >> 1)) exp_rdata = lane | ~mask;
        else exp_rdata = lane;
      end
    end else if (sz == 2'b10) begin
      exp_wr_k = 1; exp_resp_k = 2; exp_nwr = 1; exp_wdata = wd;
    end else begin
      exp_wr_k = lat + 1; exp_resp_k = lat + 2; exp_nwr = 1;
      exp_wdata = (word & ~(mask << sh)) | ((wd & mask) << sh);
    end

    check("ready_idle", 32'(o_ready), 32'h1);
    sel = s; d_valid = 1'b1; d_write = wr; d_size = sz; d_uns = un; d_addr = ad; d_wdata = wd;
    resp_k = 0; wr_k = 0; nwr = 0; got = 32'h0; rs_err = 1'b0; rs_addr = 32'h0;
    wr_addr = 32'h0; wr_data = 32'h0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      check("ready_busy", 32'(o_ready), 32'h0);
      if (o_mem_write) begin
        nwr++; wr_k = k; wr_addr = o_mem_address; wr_data = o_mem_wdata;
      end
      if (o_resp_valid) begin
        resp_k = k; got = o_resp_rdata; rs_err = o_resp_err; rs_addr = o_mem_address;
        break;
      end
      // Junk request while busy; must be ignored.
      d_valid = 1'($urandom_range(0, 1)); d_write = 1'($urandom); d_size = 2'($urandom);
      d_uns = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
    end
    d_valid = 1'b0;

    check("resp_cycle", 32'(resp_k), 32'(exp_resp_k));
    check("resp_err", 32'(rs_err), 32'(exp_err));
    check("resp_rdata", got, exp_rdata);
    check("resp_mem_addr", rs_addr, 32'h0);
    check("write_count", 32'(nwr), 32'(exp_nwr));
    check("write_cycle", 32'(wr_k), 32'(exp_wr_k));
    if (exp_nwr != 0) begin
      check("write_addr", wr_addr, {ad[31:2], 2'b00});
      check("write_data", wr_data, exp_wdata);
      mm[s][idx] = exp_wdata;
    end
    @(negedge clock);
    check("resp_pulse", 32'(o_resp_valid), 32'h0);
    check("ready_back", 32'(o_ready), 32'h1);
  endtask

  logic [31:0] r;
  int          nbad;

  initial begin
    reset = 1'b1; load_img = 1'b1; sel = 1'b0;
    d_valid = 1'b0; d_write = 1'b0; d_size = 2'b00; d_uns = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    for (int i = 0; i < 64; i++) img[i] = $urandom;
    img[4] = 32'h8899AABB;
    for (int i = 0; i < 64; i++) begin mm[0][i] = img[i]; mm[1][i] = img[i]; end
    repeat (2) @(negedge clock);
    load_img = 1'b0;
    check("rst_ready", 32'(o_ready), 32'h1);
    check("rst_resp_valid", 32'(o_resp_valid), 32'h0);
    check("rst_rdata", o_resp_rdata, 32'h0);
    check("rst_err", 32'(o_resp_err), 32'h0);
    check("rst_mem_write", 32'(o_mem_write), 32'h0);
    check("rst_mem_addr", o_mem_address, 32'h0);
    check("rst_mem_wdata", o_mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    do_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, r); check("lb_0x11", r, 32'hFFFFFFAA);
    do_req(1'b0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, r); check("lbu_0x11", r, 32'h000000AA);
    do_req(1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, r); check("lh_0x12", r, 32'hFFFF8899);
    do_req(1'b0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, r); check("lhu_0x12", r, 32'h00008899);
    do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345677, r);
    check("sb_word", dmem0[4], 32'h7799AABB);
    do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h1111_2222, r);
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h3333_4444, r);
    do_req(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h5555_6666, r);
    do_req(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, r);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, r);
    check("mis_word", dmem0[4], 32'h7799AABB);
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, r);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r); check("lw_0x10", r, 32'hDEADBEEF);

    do_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345677, r);
    check("sb_l3_word", dmem1[4], 32'h7799AABB);

    // Reset during the READ cycle of a sub-word store.
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, r);
    sel = 1'b0; d_valid = 1'b1; d_write = 1'b1; d_size = 2'b00; d_uns = 1'b0;
    d_addr = 32'h13; d_wdata = 32'h12345677;
    @(negedge clock);
    d_valid = 1'b0;
    check("rmid_busy", 32'(o_ready), 32'h0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    nbad = 0;
    for (int k = 0; k < 5; k++) begin
      if (o_mem_write || o_resp_valid || !o_ready) nbad++;
      @(negedge clock);
    end
    check("rmid_quiet", 32'(nbad), 32'h0);
    check("rmid_word", dmem0[4], mm[0][4]);
    check("rmid_ready", 32'(o_ready), 32'h1);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] ad;
      ad = $urandom;
      if ($urandom_range(0, 1) == 0) ad[1:0] = 2'b00;
      do_req(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), ad, $urandom, r);
    end

    nbad = 0;
    for (int i = 0; i < 64; i++) begin
      if (dmem0[i] !== mm[0][i]) nbad++;
      if (dmem1[i] !== mm[1][i]) nbad++;
    end
    check("final_mem", 32'(nbad), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
